ray_dispatcher: RTL
===================

// Module: ray_dispatcher
// PURPOSE
//  Fans rays from the ray generator out to NUM_UNITS parallel ray units.
//  Upstream, it presents the generator with a single-unit start/ready/busy handshake.
//  Holds one ray in a buffer and grants it to a ready unit using round-robin order.
//  Aggregates unit busy so the generator and config block see one "frame busy".
// PARAMETERS
//  POSITION_WIDTH  16  width of each rayV component
//  ADDRESS_WIDTH   32  width of pixel address
//  NUM_UNITS       4   number of downstream ray units (>=1)
// PORTS
//  clock          in   1                  system clock
//  reset          in   1                  async, active-high
//  start          in   1                  generator: one-cycle ray-valid strobe
//  rayV           in   3xPOSITION_WIDTH   ray direction, valid with start
//  rayAddress     in   ADDRESS_WIDTH      pixel address, valid with start
//  ready          out  1                  dispatcher can accept start this cycle
//  busy           out  1                  ray buffered, or any unit busy
//  unitStart      out  NUM_UNITS          one-hot start strobe to a unit
//  unitRayV       out  3xPOSITION_WIDTH   shared ray data to units
//  unitAddress    out  ADDRESS_WIDTH      shared pixel address to units
//  unitReady      in   NUM_UNITS          unit i can accept start
//  unitBusy       in   NUM_UNITS          unit i is tracing
// BEHAVIOUR
//  - State: bufValid (1b), bufV/bufAddr regs, ptr (clog2(NUM_UNITS), min 1b).
//  - Grant (comb): first i in ptr, ptr+1, ... (mod NUM_UNITS) with unitReady[i]=1.
//    grantValid = bufValid & |unitReady.
//  - unitStart[g] = grantValid (one-hot, at most one bit); unitRayV/unitAddress = bufV/bufAddr.
//  - On grant: ptr <= (g+1) mod NUM_UNITS; bufValid <= 0, unless refilled the same cycle.
//  - ready = ~bufValid | grantValid. This allows same-cycle refill, giving 1 ray/cycle throughput.
//  - start & ready: latch rayV/rayAddress, bufValid <= 1. Latency start->unitStart is 1 cycle minimum.
//  - start & ~ready: protocol violation. Ray is dropped and the buffer is unchanged.
//  - No unit ready: ray is held indefinitely, ready=0. ptr does not move.
//  - busy = bufValid | (|unitBusy). This is combinational, so busy stays high until the last unit drops busy.
//  - NUM_UNITS=1: ptr is held at 0 and the grant is simply unitReady[0].
//  - Reset (any time, async): bufValid=0, ptr=0, buffer regs=0. Buffered ray is discarded.
//    Outputs while in reset: unitStart=0, ready=1, busy=|unitBusy, unitRayV/unitAddress=0.
// CONFIGURATION
//  Macro RAY_DISPATCH_STATS_EN.
//  - Defined: adds outputs dispatchCount[NUM_UNITS][31:0], stallCycles[31:0] and dropCount[15:0].
//    dispatchCount[i] increments on each unitStart[i].
//    stallCycles increments on each cycle with bufValid & ~|unitReady.
//    dropCount increments on start & ~ready.
//    All counters saturate, and all are cleared by reset.
//  - Undefined: these ports and counters do not exist. Dispatch behaviour is identical in both builds.
// STRUCTURE
//  - Package ray_dispatch_pkg holds:
//    - typedef ray_t {V[3], address}, parameterised via localparam widths;
//    - function rr_next(ptr, n).
//  - Sub-module rr_arbiter #(N): inputs req[N] and ptr; outputs onehot grant, grant index and any.
//    It is purely combinational and reusable by the memory-bus arbiter.
//  - The top holds the buffer, ptr and (optional) stats.
// TESTING
//  1. NUM_UNITS=4, all ready; 8 back-to-back starts (addr 0..7).
//     -> unitStart order is 0,1,2,3,0,1,2,3, each 1 cycle after its start; ready stays 1.
//  2. unitReady=4'b0100, ptr=0; one start, addr 0x40.
//     -> unitStart=4'b0100 next cycle with unitAddress=0x40; ptr becomes 3.
//  3. unitReady=0; start addr 0x10, then raise unitReady[1] after 5 cycles.
//     -> ready=0 and stall=5; then unitStart[1] is issued with addr 0x10.
//  4. Hold ray with unitReady=0; assert start again with addr 0x20.
//     -> second ray dropped, first delivered; with STATS_EN, dropCount=1.
//  5. Assert reset while bufValid=1.
//     -> no unitStart follows; ready=1, ptr=0 after reset release.
//  6. unitBusy=4'b0010, buffer empty -> busy=1; unitBusy=0 -> busy=0 in the same cycle.

Source files
------------

// File: rtl/ray_dispatch_pkg.sv
// Shared types and helpers for the ray dispatcher and its round-robin arbiter.
package ray_dispatch_pkg;
   localparam int POS_W  = 16;
   localparam int ADDR_W = 32;

   typedef struct packed {
      logic [2:0][POS_W-1:0] V;
      logic [ADDR_W-1:0]     address;
   } ray_t;

   // Round-robin successor of ptr in a ring of n entries
   function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
      if (n <= 1) return 0;
      return (ptr + 1 >= n) ? 0 : ptr + 1;
   endfunction
endpackage

// File: rtl/ray_dispatcher_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after ptr.
module rr_arbiter #(
   parameter int N  = 4,
   parameter int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  i_req,
   input  logic [PW-1:0] i_ptr,
   output logic [N-1:0]  o_grant,
   output logic [PW-1:0] o_idx,
   output logic          o_any
);
   // Scan offsets from farthest to nearest so the nearest requester wins
   always_comb begin
      int j;
      j       = 0;
      o_grant = '0;
      o_idx   = '0;
      o_any   = |i_req;
      for (int k = N - 1; k >= 0; k--) begin
         j = int'(i_ptr) + k;
         if (j >= N) j = j - N;
         if (i_req[j]) begin
            o_grant    = '0;
            o_grant[j] = 1'b1;
            o_idx      = PW'(j);
         end
      end
   end
endmodule

// File: rtl/ray_dispatcher.sv
// Ray dispatcher: one-ray buffer fanned out round-robin to NUM_UNITS ray units.
// Optional statistics counters are built when RAY_DISPATCH_STATS_EN is defined.
module ray_dispatcher
   import ray_dispatch_pkg::*;
#(
   parameter int POSITION_WIDTH = 16,
   parameter int ADDRESS_WIDTH  = 32,
   parameter int NUM_UNITS      = 4
) (
   input  logic                           i_clock,
   input  logic                           i_reset,
   input  logic                           i_start,
   input  logic [2:0][POSITION_WIDTH-1:0] i_rayV,
   input  logic [ADDRESS_WIDTH-1:0]       i_rayAddress,
   output logic                           o_ready,
   output logic                           o_busy,
   output logic [NUM_UNITS-1:0]           o_unitStart,
   output logic [2:0][POSITION_WIDTH-1:0] o_unitRayV,
   output logic [ADDRESS_WIDTH-1:0]       o_unitAddress,
   input  logic [NUM_UNITS-1:0]           i_unitReady,
   input  logic [NUM_UNITS-1:0]           i_unitBusy
`ifdef RAY_DISPATCH_STATS_EN
   ,
   output logic [NUM_UNITS-1:0][31:0]     o_dispatchCount,
   output logic [31:0]                    o_stallCycles,
   output logic [15:0]                    o_dropCount
`endif
);
   localparam int PW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

   logic                           r_bufValid;
   logic [2:0][POSITION_WIDTH-1:0] r_bufV;
   logic [ADDRESS_WIDTH-1:0]       r_bufAddr;
   logic [PW-1:0]                  r_ptr;

   logic [NUM_UNITS-1:0] w_grant;
   logic [PW-1:0]        w_idx;
   logic                 w_any;
   logic                 w_grantValid;
   logic                 w_accept;

   rr_arbiter #(.N(NUM_UNITS), .PW(PW)) u_arb (
      .i_req   (i_unitReady),
      .i_ptr   (r_ptr),
      .o_grant (w_grant),
      .o_idx   (w_idx),
      .o_any   (w_any)
   );

   assign w_grantValid  = r_bufValid & w_any;
   assign o_ready       = ~r_bufValid | w_grantValid;
   assign w_accept      = i_start & o_ready;
   assign o_busy        = r_bufValid | (|i_unitBusy);
   assign o_unitStart   = w_grantValid ? w_grant : '0;
   assign o_unitRayV    = r_bufV;
   assign o_unitAddress = r_bufAddr;

   // Buffer fill/drain and pointer advance; a grant and a refill may share a cycle
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_bufValid <= 1'b0;
         r_bufV     <= '0;
         r_bufAddr  <= '0;
         r_ptr      <= '0;
      end else begin
         if (w_grantValid)
            r_ptr <= PW'(rr_next(32'(w_idx), NUM_UNITS));
         if (w_accept) begin
            r_bufValid <= 1'b1;
            r_bufV     <= i_rayV;
            r_bufAddr  <= i_rayAddress;
         end else if (w_grantValid) begin
            r_bufValid <= 1'b0;
         end
      end
   end

`ifdef RAY_DISPATCH_STATS_EN
   logic [NUM_UNITS-1:0][31:0] r_dispatchCount;
   logic [31:0]                r_stallCycles;
   logic [15:0]                r_dropCount;

   // Saturating statistics: per-unit dispatches, no-unit-ready stalls, dropped starts
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_dispatchCount <= '0;
         r_stallCycles   <= '0;
         r_dropCount     <= '0;
      end else begin
         for (int u = 0; u < NUM_UNITS; u++)
            if (o_unitStart[u] && (r_dispatchCount[u] != '1))
               r_dispatchCount[u] <= r_dispatchCount[u] + 32'd1;
         if (r_bufValid && !w_any && (r_stallCycles != '1))
            r_stallCycles <= r_stallCycles + 32'd1;
         if (i_start && !o_ready && (r_dropCount != '1))
            r_dropCount <= r_dropCount + 16'd1;
      end
   end

   assign o_dispatchCount = r_dispatchCount;
   assign o_stallCycles   = r_stallCycles;
   assign o_dropCount     = r_dropCount;
`endif
endmodule
